// File: rtl/traffic_light_monitor.sv
// Receive-side monitor for the 4-way controller's light codes: mirrors healthy codes to the
// lamp heads and latches a fault (flashing red on both heads) on any illegal condition.
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_LEN = 2,
  parameter int TIMEOUT    = 16,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       clear_fault,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] monitor_state
);

  localparam int DW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);

  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [DW-1:0] DWELL_ONE = DW'(1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(TIMEOUT);
  localparam logic [DW-1:0] YELLOW_D  = DW'(YELLOW_LEN);
  localparam logic [DW-1:0] GREEN_D   = DW'(GREEN_MIN);

  localparam logic [FW-1:0] FLASH_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FLASH_ONE  = FW'(1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_DARK = FW'(FLASH_HALF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t        state_r, state_n;
  logic [2:0]    prev_ns_r, prev_ew_r, prev_ns_n, prev_ew_n;
  logic [2:0]    ns_lamp_r, ew_lamp_r, ns_lamp_n, ew_lamp_n;
  logic          fault_r, fault_n;
  logic [2:0]    code_r, code_n;
  logic [DW-1:0] dwell_r, dwell_n, dwell_inc_s;
  logic [FW-1:0] flash_r, flash_n, flash_inc_s;
  logic          changed_s;
  logic          chk_e_s, chk_c_s, chk_s_s, chk_y_s, chk_g_s, chk_t_s;
  logic [2:0]    viol_s;

  function automatic logic legal_code(input logic [2:0] c);
    return (c == GRN) || (c == YEL) || (c == RED);
  endfunction

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return (c == p) || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
  endfunction

  // Raw rule checks of the current sample against the previous accepted sample.
  always_comb begin
    changed_s = (ns_light != prev_ns_r) || (ew_light != prev_ew_r);
    if (changed_s) begin
      dwell_inc_s = DWELL_ONE;
    end else if (dwell_r == DWELL_MAX) begin
      dwell_inc_s = DWELL_MAX;
    end else begin
      dwell_inc_s = dwell_r + DWELL_ONE;
    end
    chk_e_s = !legal_code(ns_light) || !legal_code(ew_light);
    chk_c_s = (ns_light != RED) && (ew_light != RED);
    chk_s_s = !legal_step(prev_ns_r, ns_light) || !legal_step(prev_ew_r, ew_light);
    chk_y_s = changed_s && (prev_ns_r == YEL || prev_ew_r == YEL) && (dwell_r != YELLOW_D);
    chk_g_s = changed_s && (prev_ns_r == GRN || prev_ew_r == GRN) && (dwell_r < GREEN_D);
    chk_t_s = !changed_s && (dwell_inc_s == DWELL_MAX);
    flash_inc_s = (flash_r == FLASH_LAST) ? FLASH_ZERO : flash_r + FLASH_ONE;
  end

  // Lowest enabled code wins; IDLE only trusts encoding/conflict, SYNC skips dwell-of-phase checks.
  always_comb begin
    viol_s = 3'd0;
    if (chk_e_s) begin
      viol_s = 3'd1;
    end else if (chk_c_s) begin
      viol_s = 3'd2;
    end else if (chk_s_s && state_r != ST_IDLE) begin
      viol_s = 3'd3;
    end else if (chk_y_s && state_r == ST_RUN) begin
      viol_s = 3'd4;
    end else if (chk_g_s && state_r == ST_RUN) begin
      viol_s = 3'd5;
    end else if (chk_t_s && state_r != ST_IDLE) begin
      viol_s = 3'd6;
    end else begin
      viol_s = 3'd0;
    end
  end

  // Next-state, lamp drive and bookkeeping for the monitor FSM.
  always_comb begin
    state_n   = state_r;
    prev_ns_n = prev_ns_r;
    prev_ew_n = prev_ew_r;
    ns_lamp_n = ns_lamp_r;
    ew_lamp_n = ew_lamp_r;
    fault_n   = fault_r;
    code_n    = code_r;
    dwell_n   = dwell_r;
    flash_n   = flash_r;
    case (state_r)
      ST_IDLE, ST_SYNC, ST_RUN: begin
        if (viol_s != 3'd0) begin
          state_n   = ST_FAULT;
          fault_n   = 1'b1;
          code_n    = viol_s;
          ns_lamp_n = RED;
          ew_lamp_n = RED;
          flash_n   = FLASH_ZERO;
        end else begin
          ns_lamp_n = ns_light;
          ew_lamp_n = ew_light;
          prev_ns_n = ns_light;
          prev_ew_n = ew_light;
          if (state_r == ST_IDLE) begin
            dwell_n = DWELL_ONE;
            state_n = ST_SYNC;
          end else if (state_r == ST_SYNC && changed_s) begin
            dwell_n = dwell_inc_s;
            state_n = ST_RUN;
          end else begin
            dwell_n = dwell_inc_s;
          end
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_n   = ST_IDLE;
          fault_n   = 1'b0;
          code_n    = 3'd0;
          ns_lamp_n = RED;
          ew_lamp_n = RED;
          prev_ns_n = RED;
          prev_ew_n = RED;
          dwell_n   = DWELL_ONE;
          flash_n   = FLASH_ZERO;
        end else begin
          flash_n   = flash_inc_s;
          ns_lamp_n = (flash_inc_s < FLASH_DARK) ? RED : DARK;
          ew_lamp_n = (flash_inc_s < FLASH_DARK) ? RED : DARK;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        fault_n   = 1'b0;
        code_n    = 3'd0;
        ns_lamp_n = RED;
        ew_lamp_n = RED;
        dwell_n   = DWELL_ONE;
        flash_n   = FLASH_ZERO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      prev_ns_r <= RED;
      prev_ew_r <= RED;
      ns_lamp_r <= RED;
      ew_lamp_r <= RED;
      fault_r   <= 1'b0;
      code_r    <= 3'd0;
      dwell_r   <= DWELL_ONE;
      flash_r   <= FLASH_ZERO;
    end else begin
      state_r   <= state_n;
      prev_ns_r <= prev_ns_n;
      prev_ew_r <= prev_ew_n;
      ns_lamp_r <= ns_lamp_n;
      ew_lamp_r <= ew_lamp_n;
      fault_r   <= fault_n;
      code_r    <= code_n;
      dwell_r   <= dwell_n;
      flash_r   <= flash_n;
    end
  end

  assign ns_lamp       = ns_lamp_r;
  assign ew_lamp       = ew_lamp_r;
  assign fault         = fault_r;
  assign fault_code    = code_r;
  assign monitor_state = state_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, hand-written corner sequences, and random
// controller traffic compared against a history-based reference model.
module tb_traffic_light_monitor;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;
  localparam int GREEN_MIN  = 4;
  localparam int YELLOW_LEN = 2;
  localparam int TIMEOUT    = 16;
  localparam int FLASH_HALF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_fault;
  logic [2:0] ns_light, ew_light, ns_lamp, ew_lamp, fault_code;
  logic       fault;
  logic [1:0] monitor_state;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .ns_light(ns_light), .ew_light(ew_light),
    .clear_fault(clear_fault), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .fault(fault), .fault_code(fault_code), .monitor_state(monitor_state)
  );

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       clr;
    logic [2:0] ens;
    logic [2:0] eew;
    logic       ef;
    logic [2:0] ec;
    logic [1:0] es;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [2:0] ens, input logic [2:0] eew,
                       input logic ef, input logic [2:0] ec, input logic [1:0] es);
    total++;
    if (ns_lamp !== ens || ew_lamp !== eew || fault !== ef || fault_code !== ec || monitor_state !== es) begin
      bad++;
      $display("FAIL %s: got lamps=%b/%b fault=%b code=%0d state=%0d, want lamps=%b/%b fault=%b code=%0d state=%0d",
               name, ns_lamp, ew_lamp, fault, fault_code, monitor_state, ens, eew, ef, ec, es);
    end
  endtask

  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    ns_light = ns;
    ew_light = ew;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ns_light = R;
    ew_light = R;
    clear_fault = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reset, then a legal start so the monitor is in RUN holding R/Y for 2 cycles.
  task automatic to_run();
    do_reset();
    step(G, R, 1'b0); step(G, R, 1'b0);
    step(Y, R, 1'b0); step(Y, R, 1'b0);
    repeat (4) step(R, G, 1'b0);
    repeat (2) step(R, Y, 1'b0);
  endtask

  // ---------------- reference model (sample history based) ----------------
  int         m_mode;
  logic [5:0] m_hist[$];
  int         m_age;
  logic [2:0] m_ns, m_ew, m_code;
  logic       m_fault;

  function automatic bit legal(input logic [2:0] c);
    return c == G || c == Y || c == R;
  endfunction

  function automatic bit ok_step(input logic [2:0] p, input logic [2:0] c);
    logic [2:0] nx;
    nx = (p == G) ? Y : (p == Y) ? R : G;
    return c == p || c == nx;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hist.delete(); m_age = 0;
    m_ns = R; m_ew = R; m_fault = 1'b0; m_code = 3'd0;
  endtask

  task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    logic [5:0] cur, prev;
    int run, held, v;
    bit changed;
    cur = {ns, ew};
    prev = 6'd0;
    run = 0;
    if (m_mode == 3) begin
      if (clr) begin
        m_mode = 0; m_fault = 1'b0; m_code = 3'd0; m_ns = R; m_ew = R; m_hist.delete();
      end else begin
        m_age++;
        if ((m_age / FLASH_HALF) % 2 == 0) begin m_ns = R; m_ew = R; end
        else begin m_ns = D; m_ew = D; end
      end
    end else begin
      if (m_mode == 0) m_hist.delete();
      if (m_hist.size() > 0) begin
        prev = m_hist[$];
        for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == prev; i--) run++;
      end
      changed = (m_mode != 0) && (cur != prev);
      held = changed ? 1 : run + 1;
      v = 0;
      if (!legal(ns) || !legal(ew)) v = 1;
      else if (ns != R && ew != R) v = 2;
      else if (m_mode > 0 && (!ok_step(prev[5:3], ns) || !ok_step(prev[2:0], ew))) v = 3;
      else if (m_mode == 2 && changed && (prev[5:3] == Y || prev[2:0] == Y) && run != YELLOW_LEN) v = 4;
      else if (m_mode == 2 && changed && (prev[5:3] == G || prev[2:0] == G) && run < GREEN_MIN) v = 5;
      else if (m_mode > 0 && !changed && held == TIMEOUT) v = 6;
      if (v != 0) begin
        m_mode = 3; m_fault = 1'b1; m_code = 3'(v); m_ns = R; m_ew = R; m_age = 0;
      end else begin
        m_ns = ns; m_ew = ew;
        m_hist.push_back(cur);
        if (m_hist.size() > 40) void'(m_hist.pop_front());
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && changed) m_mode = 2;
      end
    end
  endtask

  logic [5:0] pairs[4] = '{{G, R}, {Y, R}, {R, G}, {R, Y}};

  initial begin
    reset = 1'b1;
    ns_light = R; ew_light = R; clear_fault = 1'b0;
    #1;
    check("reset_values", R, R, 1'b0, 3'd0, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // legal cycle, conflict, flash, clear and re-sync
    tbl.push_back('{G, R, 1'b0, G, R, 1'b0, 3'd0, 2'd1});
    tbl.push_back('{G, R, 1'b0, G, R, 1'b0, 3'd0, 2'd1});
    tbl.push_back('{Y, R, 1'b0, Y, R, 1'b0, 3'd0, 2'd2});
    tbl.push_back('{Y, R, 1'b0, Y, R, 1'b0, 3'd0, 2'd2});
    for (int i = 0; i < 4; i++) tbl.push_back('{R, G, 1'b0, R, G, 1'b0, 3'd0, 2'd2});
    for (int i = 0; i < 2; i++) tbl.push_back('{R, Y, 1'b0, R, Y, 1'b0, 3'd0, 2'd2});
    for (int i = 0; i < 4; i++) tbl.push_back('{G, R, 1'b0, G, R, 1'b0, 3'd0, 2'd2});
    for (int i = 0; i < 2; i++) tbl.push_back('{Y, R, 1'b0, Y, R, 1'b0, 3'd0, 2'd2});
    tbl.push_back('{G, G, 1'b0, R, R, 1'b1, 3'd2, 2'd3});
    tbl.push_back('{G, G, 1'b0, R, R, 1'b1, 3'd2, 2'd3});
    tbl.push_back('{Y, Y, 1'b0, D, D, 1'b1, 3'd2, 2'd3});
    tbl.push_back('{D, D, 1'b0, D, D, 1'b1, 3'd2, 2'd3});
    tbl.push_back('{R, R, 1'b0, R, R, 1'b1, 3'd2, 2'd3});
    tbl.push_back('{G, R, 1'b1, R, R, 1'b0, 3'd0, 2'd0});
    tbl.push_back('{G, R, 1'b0, G, R, 1'b0, 3'd0, 2'd1});
    tbl.push_back('{Y, R, 1'b0, Y, R, 1'b0, 3'd0, 2'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ns, tbl[i].ew, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].ens, tbl[i].eew, tbl[i].ef, tbl[i].ec, tbl[i].es);
    end

    // bad sequence outranks other checks
    to_run();
    repeat (4) step(G, R, 1'b0);
    check("green4_ok", G, R, 1'b0, 3'd0, 2'd2);
    step(R, G, 1'b0);
    check("bad_sequence", R, R, 1'b1, 3'd3, 2'd3);

    // yellow held 3 cycles
    to_run();
    repeat (4) step(G, R, 1'b0);
    repeat (3) step(Y, R, 1'b0);
    check("yellow3_held", Y, R, 1'b0, 3'd0, 2'd2);
    step(R, G, 1'b0);
    check("yellow_len", R, R, 1'b1, 3'd4, 2'd3);

    // green held 3 cycles
    to_run();
    repeat (3) step(G, R, 1'b0);
    step(Y, R, 1'b0);
    check("short_green", R, R, 1'b1, 3'd5, 2'd3);

    // conflict wins over bad sequence
    to_run();
    step(G, G, 1'b0);
    check("conflict_over_seq", R, R, 1'b1, 3'd2, 2'd3);

    // stuck timeout on the 16th identical sample
    do_reset();
    repeat (TIMEOUT - 1) step(G, R, 1'b0);
    check("hold15_ok", G, R, 1'b0, 3'd0, 2'd1);
    step(G, R, 1'b0);
    check("stuck16", R, R, 1'b1, 3'd6, 2'd3);

    // bad encoding in IDLE, including with a simultaneous conflict
    do_reset();
    step(3'b011, R, 1'b0);
    check("bad_enc_idle", R, R, 1'b1, 3'd1, 2'd3);
    do_reset();
    step(3'b011, 3'b011, 1'b0);
    check("bad_enc_over_conflict", R, R, 1'b1, 3'd1, 2'd3);

    // reset in the dark half of the flash
    to_run();
    step(G, G, 1'b0);
    step(R, R, 1'b0);
    step(R, R, 1'b0);
    check("flash_dark", D, D, 1'b1, 3'd2, 2'd3);
    #3;
    reset = 1'b1;
    #1;
    check("reset_mid_flash", R, R, 1'b0, 3'd0, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // random controller traffic against the reference model
    do_reset();
    model_reset();
    begin
      int ph, left;
      ph = 0;
      left = 4;
      for (int c = 0; c < 2000; c++) begin
        logic [2:0] ns, ew;
        logic clr;
        if (left == 0) begin
          ph = (ph + 1) % 4;
          if (ph % 2 == 0) left = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(4, 7));
          else left = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 2;
          if ($urandom_range(0, 30) == 0) left = 18;
        end
        {ns, ew} = pairs[ph];
        left--;
        if ($urandom_range(0, 49) == 0) ns = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 49) == 0) ew = 3'($urandom_range(0, 7));
        clr = (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
        model_step(ns, ew, clr);
        step(ns, ew, clr);
        check($sformatf("rand%0d", c), m_ns, m_ew, m_fault, m_code, 2'(m_mode));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
